// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader.
// State encoding and word geometry used by the FSM and the byte packer.
package loader_pkg;

    localparam int WORD_BYTES = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RECV  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

endpackage

// File: rtl/byte_packer.sv
// Assembles big-endian bytes into 32-bit words.
// Bytes not received before the closing byte stay zero (padding).
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_data,
    input  logic        i_last,
    output logic [31:0] o_word,
    output logic        o_close,
    output logic        o_last
);

    localparam int CNT_W = $clog2(WORD_BYTES);

    logic [31:0]      r_word;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last;
    logic             w_full;

    assign w_full  = (r_cnt == CNT_W'(WORD_BYTES - 1));
    assign o_close = i_accept && (i_last || w_full);
    assign o_word  = r_word;
    assign o_last  = r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_cnt  <= '0;
            r_last <= 1'b0;
        end else if (i_clear) begin
            r_word <= '0;
            r_cnt  <= '0;
            r_last <= 1'b0;
        end else if (i_accept) begin
            unique case (r_cnt)
                2'd0:    r_word[31:24] <= i_data;
                2'd1:    r_word[23:16] <= i_data;
                2'd2:    r_word[15:8]  <= i_data;
                default: r_word[7:0]   <= i_data;
            endcase
            if (o_close) begin
                r_cnt  <= '0;
                r_last <= i_last;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Streams a byte image into instruction memory while holding the CPU.
// FSM and write pointer live here; word assembly is in byte_packer.
module program_loader
    import loader_pkg::*;
#(
    parameter int              ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              Clk,
    input  logic              R,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    // Highest word-aligned address; writing there without byte_last overflows.
    localparam logic [ADDR_W-1:0] LAST_PTR = {{(ADDR_W-2){1'b1}}, 2'b00};

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_ptr;

    logic        w_recv;
    logic        w_write;
    logic        w_accept;
    logic        w_begin;
    logic        w_clear;
    logic        w_close;
    logic        w_last;
    logic [31:0] w_word;

    assign w_recv   = (r_state == ST_RECV);
    assign w_write  = (r_state == ST_WRITE);
    assign w_accept = byte_valid && w_recv;
    assign w_begin  = start && ((r_state == ST_IDLE) ||
                                (r_state == ST_DONE) ||
                                (r_state == ST_ERROR));
    assign w_clear  = w_begin || w_write;

    byte_packer u_packer (
        .clk      (Clk),
        .rst_n    (R),
        .i_clear  (w_clear),
        .i_accept (w_accept),
        .i_data   (byte_data),
        .i_last   (byte_last),
        .o_word   (w_word),
        .o_close  (w_close),
        .o_last   (w_last)
    );

    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        r_state <= ST_RECV;
                        r_ptr   <= BASE_ADDR;
                    end
                end
                ST_RECV: begin
                    if (w_close) begin
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end else if (r_ptr == LAST_PTR) begin
                        r_state <= ST_ERROR;
                    end else begin
                        r_ptr   <= r_ptr + ADDR_W'(4);
                        r_state <= ST_RECV;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign byte_ready = w_recv;
    assign mem_we     = w_write;
    assign mem_addr   = w_write ? r_ptr : '0;
    assign mem_wdata  = w_write ? w_word : '0;
    assign cpu_hold   = (r_state != ST_DONE);
    assign done       = (r_state == ST_DONE);
    assign err        = (r_state == ST_ERROR);

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: memory byte-address width.
REQ-002 SHALL have parameter BASE_ADDR, default 0: first byte address written; word-aligned.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 R  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a load session.
REQ-006 byte_valid  input  1  byte_data holds a program byte.
REQ-007 byte_data  input  8  program byte; first byte of each word is its MSB (big-endian).
REQ-008 byte_last  input  1  qualifies byte_valid; marks the final byte of the image.
REQ-009 byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 mem_we  output  1  one-cycle word write strobe to instruction memory.
REQ-011 mem_addr  output  ADDR_W  byte address of the written word, multiple of 4.
REQ-012 mem_wdata  output  32  assembled word.
REQ-013 cpu_hold  output  1  holds PC/nPC and pipeline registers in reset while high.
REQ-014 done  output  1  image fully written.
REQ-015 err  output  1  image exceeded memory; session aborted.

Function
REQ-016 SHALL implement FSM states IDLE, RECV, WRITE, DONE, ERROR.
REQ-017 A byte SHALL be accepted only at a rising edge with byte_valid=1 and byte_ready=1.
REQ-018 byte_ready SHALL be 1 only in RECV; 0 in all other states.
REQ-019 IDLE->RECV on start; write pointer loaded with BASE_ADDR, byte counter cleared.
REQ-020 RECV->WRITE on acceptance of the 4th byte of a word, or of any byte with byte_last=1.
REQ-021 Partial final word SHALL be padded with 0x00 in unfilled low-order bytes.
REQ-022 In WRITE, mem_we=1 for exactly one cycle with mem_addr=pointer and mem_wdata=assembled word; latency from accepting the closing byte to mem_we is 1 cycle.
REQ-023 WRITE->DONE if closing byte had byte_last=1; else, if pointer = 2^ADDR_W-4, WRITE->ERROR; else pointer+=4, WRITE->RECV.
REQ-024 mem_we, mem_addr, mem_wdata SHALL be 0 outside WRITE.
REQ-025 DONE: done=1, cpu_hold=0; ERROR: err=1, cpu_hold=1.
REQ-026 start SHALL be ignored in RECV and WRITE; in DONE or ERROR it SHALL clear done/err, assert cpu_hold, and enter RECV as in REQ-019.
REQ-027 byte_valid with byte_ready=0 SHALL have no effect; byte_data/byte_last sampled only on acceptance.
REQ-028 Pointer arithmetic is ADDR_W bits, no wrap: overflow handled only by REQ-023.

Reset
REQ-029 On R=0, immediately: state=IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, err=0, byte counter and assembled word cleared.
REQ-030 Reset mid-session SHALL discard any partial word without issuing a write.

Structure
REQ-031 Shared package loader_pkg SHALL hold the state encoding and constant WORD_BYTES=4.
REQ-032 Byte assembly, padding and byte count SHALL be a sub-module byte_packer; FSM and pointer remain in program_loader.

Verification
REQ-033 start; bytes 82 10 20 05 C2 00 60 04 (last on 8th) -> mem_we writes 0x82102005@0 then 0xC2006004@4, done=1, cpu_hold=0.
REQ-034 Same image with byte_valid low every other cycle -> identical writes; byte_ready=0 during each WRITE cycle, no byte lost.
REQ-035 Bytes AA BB CC DD EE FF (last on FF) -> 0xAABBCCDD@0, 0xEEFF0000@4, done=1.
REQ-036 ADDR_W=4, 20 bytes, no last -> writes at 0,4,8,12 only; err=1, byte_ready=0, cpu_hold=1 thereafter.
REQ-037 R=0 after 2 bytes accepted -> no mem_we, all outputs at REQ-029 values; restart writes first word at BASE_ADDR.
REQ-038 start pulse during RECV ignored (pointer unchanged); start in DONE -> cpu_hold=1, done=0, next image written from BASE_ADDR.
